// File: rtl/fpu_operand_sequencer.sv
// Pairs consecutive input words into adder operands A/B, bypasses zero and
// exact-cancellation cases, and registers every sum. Optional FPU_SEQ_STATS_EN adds counters.
module fpu_operand_sequencer #(
  parameter int WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_LENGTH-1:0] in_data,
  output logic [WORD_LENGTH-1:0] fpu_a,
  output logic [WORD_LENGTH-1:0] fpu_b,
  input  logic [WORD_LENGTH-1:0] fpu_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_LENGTH-1:0] out_data,
  output logic                   out_bypass
`ifdef FPU_SEQ_STATS_EN
  ,
  output logic [15:0]            op_count,
  output logic [15:0]            bypass_count
`endif
);

  localparam logic [WORD_LENGTH-1:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [WORD_LENGTH-1:0] FP_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GET_B = 2'd1,
    EXEC  = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic [WORD_LENGTH-1:0] a_q, b_q, res_q;
  logic                   byp_q;
  logic                   a_zero, b_zero, cancel;
  logic                   byp_hit;
  logic [WORD_LENGTH-1:0] byp_val;
  logic                   out_hs;

  // Denormals flush to zero; sign is irrelevant for the zero test.
  assign a_zero = (a_q[30:23] == 8'h00);
  assign b_zero = (b_q[30:23] == 8'h00);
  assign cancel = (a_q[30:0] == b_q[30:0]) && (a_q[31] != b_q[31]);

  always_comb begin
    byp_hit = 1'b1;
    byp_val = FP_ZERO;
    if (a_zero && b_zero) byp_val = FP_ZERO;
    else if (a_zero)      byp_val = b_q;
    else if (b_zero)      byp_val = a_q;
    else if (cancel)      byp_val = FP_ZERO;
    else                  byp_hit = 1'b0;
  end

  // Adder sees 1.0+1.0 whenever its result is not used, so its normaliser
  // never spins on a zero mantissa.
  always_comb begin
    fpu_a = FP_ONE;
    fpu_b = FP_ONE;
    if (state == EXEC && !byp_hit) begin
      fpu_a = a_q;
      fpu_b = b_q;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = GET_B;
      end
      GET_B: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = EXEC;
      end
      EXEC: state_nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_hs     = out_valid && out_ready;
  assign out_data   = res_q;
  assign out_bypass = byp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      byp_q <= 1'b0;
    end else begin
      if (state == IDLE  && in_valid) a_q <= in_data;
      if (state == GET_B && in_valid) b_q <= in_data;
      if (state == EXEC) begin
        res_q <= byp_hit ? byp_val : fpu_result;
        byp_q <= byp_hit;
      end
    end
  end

`ifdef FPU_SEQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count     <= '0;
      bypass_count <= '0;
    end else if (out_hs) begin
      op_count <= op_count + 16'd1;
      if (byp_q) bypass_count <= bypass_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_operand_sequencer.sv
// Scoreboard bench for fpu_operand_sequencer: stimulus pushes expected results,
// a negedge monitor pops and compares on each output handshake. Adder is a lookup table.
module tb_fpu_operand_sequencer;

  localparam logic [31:0] ONE = 32'h3F80_0000;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic [31:0] fpu_a, fpu_b, fpu_result;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        out_bypass;
`ifdef FPU_SEQ_STATS_EN
  logic [15:0] op_count, bypass_count;
`endif

  fpu_operand_sequencer #(.WORD_LENGTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_result(fpu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_bypass(out_bypass)
`ifdef FPU_SEQ_STATS_EN
    , .op_count(op_count), .bypass_count(bypass_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in adder: only the sums this bench needs, anything else is a marker value.
  function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b);
    if      (a == ONE          && b == ONE)          return 32'h4000_0000;
    else if (a == ONE          && b == 32'h4000_0000) return 32'h4040_0000;
    else if (a == 32'h40A0_0000 && b == 32'h40A0_0000) return 32'h4120_0000;
    else if (a == 32'h7F80_0000 && b == ONE)          return 32'h7F80_0000;
    else                                              return 32'hDEAD_BEEF;
  endfunction

  always_comb fpu_result = fpu_model(fpu_a, fpu_b);

  typedef struct {
    logic [31:0] d;
    logic        b;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] cur_a = '0, cur_b = '0;
  logic        cur_nobyp = 1'b0;
  int          exp_ops = 0, exp_byp = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: results on handshake, adder operands whenever they leave 1.0/1.0.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_out: got %h with no expected result", out_data);
      end else begin
        e = q.pop_front();
        chk("out_data",   {32'h0, out_data},   {32'h0, e.d});
        chk("out_bypass", {63'h0, out_bypass}, {63'h0, e.b});
      end
    end
    if (rst_n && (fpu_a != ONE || fpu_b != ONE))
      chk("fpu_operands", {fpu_a, fpu_b}, cur_nobyp ? {cur_a, cur_b} : {ONE, ONE});
  end

  task automatic send_word(input logic [31:0] w);
    int  n = 0;
    bit  ok;
    in_valid = 1'b1;
    in_data  = w;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: in_ready stayed 0 for word %h", w);
    end
    in_valid = 1'b0;
  endtask

  // Sends A then B; checks the one-cycle EXEC gap before out_valid.
  task automatic issue_pair(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] e, input logic by);
    exp_t x;
    send_word(a);
    cur_a = a; cur_b = b; cur_nobyp = !by;
    send_word(b);
    x.d = e; x.b = by;
    q.push_back(x);
    exp_ops++;
    if (by) exp_byp++;
    chk("exec_no_valid", {63'h0, out_valid}, 64'h0);
    @(posedge clk); #1;
    chk("latency_valid", {63'h0, out_valid}, 64'h1);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d results outstanding", q.size());
      q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #12;
    chk("rst_in_ready",   {63'h0, in_ready},   64'h1);
    chk("rst_out_valid",  {63'h0, out_valid},  64'h0);
    chk("rst_out_data",   {32'h0, out_data},   64'h0);
    chk("rst_out_bypass", {63'h0, out_bypass}, 64'h0);
    chk("rst_fpu_ops",    {fpu_a, fpu_b},      {ONE, ONE});
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset mid-pair: the latched A must be discarded.
    send_word(32'h4000_0000);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", {63'h0, in_ready}, 64'h1);
    exp_ops = 0; exp_byp = 0;
    #1 rst_n = 1'b1;
    issue_pair(ONE, ONE, 32'h4000_0000, 1'b0);
    drain();

    issue_pair(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0); // 1+2
    drain();
    issue_pair(32'h0000_0000, 32'h4049_0FDB, 32'h4049_0FDB, 1'b1); // A zero
    drain();
    issue_pair(32'h40A0_0000, 32'hC0A0_0000, 32'h0000_0000, 1'b1); // cancel
    drain();
    issue_pair(32'h4049_0FDB, 32'h8000_0000, 32'h4049_0FDB, 1'b1); // B -0
    drain();
    issue_pair(32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1); // both zero
    drain();
    issue_pair(32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, 1'b1); // denormal A
    drain();
    issue_pair(32'h40A0_0000, 32'h40A0_0000, 32'h4120_0000, 1'b0); // same sign
    drain();
    issue_pair(32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 1'b0); // Inf to adder
    drain();

    // Backpressure: result must hold with input closed.
    out_ready = 1'b0;
    issue_pair(ONE, ONE, 32'h4000_0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", {63'h0, out_valid}, 64'h1);
      chk("bp_out_data",  {32'h0, out_data},  {32'h0, 32'h4000_0000});
      chk("bp_in_ready",  {63'h0, in_ready},  64'h0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready",  {63'h0, in_ready},  64'h1);
    chk("bp_release_out_valid", {63'h0, out_valid}, 64'h0);
    drain();

`ifdef FPU_SEQ_STATS_EN
    chk("op_count",     {48'h0, op_count},     exp_ops);
    chk("bypass_count", {48'h0, bypass_count}, exp_byp);
`endif
    chk("queue_empty", q.size(), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
